// File: rtl/onehot_seq_pkg.sv
// Shared types, constants and elaboration-time helpers for the one-hot sequence detector.
// kmp_next builds the pattern automaton's transition table when the design is elaborated.
package onehot_seq_pkg;

    localparam int MAX_PAT_LEN = 16;

    typedef logic [MAX_PAT_LEN:0] state_vec_t;

    localparam state_vec_t S0_ONEHOT = state_vec_t'(1);

    // Bit i of the pattern in arrival order (i = 0 is the first bit received, the MSB).
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern,
                                     input int len, input int i);
        logic [MAX_PAT_LEN-1:0] sh;
        sh = pattern >> (len - 1 - i);
        return sh[0];
    endfunction

    // Target state from Sk on bit b: the longest suffix of (first k pattern bits, b)
    // that is also a pattern prefix, capped at len. From S_len this is a proper suffix.
    function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pattern,
                                    input int len, input int k, input logic b);
        int   best;
        int   pos;
        logic seq_bit;
        logic ok;
        best = 0;
        for (int j = 1; j <= len; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    pos     = k + 1 - j + i;
                    seq_bit = (pos < k) ? pat_bit(pattern, len, pos) : b;
                    if (seq_bit != pat_bit(pattern, len, i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    function automatic logic is_onehot(input state_vec_t v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/onehot_seq_next.sv
// Combinational next-state generator: each target bit is the OR of every (source state,
// input bit) pair whose elaboration-time KMP transition lands on it.
module onehot_seq_next
    import onehot_seq_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101
) (
    input  logic [PAT_LEN:0] state,
    input  logic             in,
    input  logic             overlap,
    output logic [PAT_LEN:0] next_state
);

    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT = MAX_PAT_LEN'(PATTERN);

    for (genvar t = 0; t <= PAT_LEN; t++) begin : g_tgt
        logic [PAT_LEN:0] hit;

        for (genvar k = 0; k <= PAT_LEN; k++) begin : g_src
            // Without overlap the match state behaves exactly like S0.
            localparam int   SRC_NO = (k == PAT_LEN) ? 0 : k;
            localparam logic OV0 = (kmp_next(PAT_EXT, PAT_LEN, k, 1'b0) == t);
            localparam logic OV1 = (kmp_next(PAT_EXT, PAT_LEN, k, 1'b1) == t);
            localparam logic NO0 = (kmp_next(PAT_EXT, PAT_LEN, SRC_NO, 1'b0) == t);
            localparam logic NO1 = (kmp_next(PAT_EXT, PAT_LEN, SRC_NO, 1'b1) == t);

            assign hit[k] = state[k] & (in ? (overlap ? OV1 : NO1)
                                           : (overlap ? OV0 : NO0));
        end

        assign next_state[t] = |hit;
    end

endmodule

// File: rtl/onehot_seq_detect.sv
// One-hot serial pattern detector: enable hold, illegal-state recovery, state register,
// saturating match counter and sticky error flag around the KMP next-state generator.
module onehot_seq_detect
    import onehot_seq_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             in,
    input  logic             overlap,
    input  logic             clr,
    output logic [PAT_LEN:0] state,
    output logic [PAT_LEN:0] next_state,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             err
);

    logic [PAT_LEN:0] state_q, state_d, raw_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             illegal;

    onehot_seq_next #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_next (
        .state      (state_q),
        .in         (in),
        .overlap    (overlap),
        .next_state (raw_next)
    );

    assign illegal = !is_onehot(state_vec_t'(state_q));

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (illegal) begin
            state_d = S0_ONEHOT[PAT_LEN:0];
            err_d   = 1'b1;
        end else if (en) begin
            state_d = raw_next;
            if (raw_next[PAT_LEN] && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S0_ONEHOT[PAT_LEN:0];
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign state      = state_q;
    assign next_state = state_d;
    assign out        = state_q[PAT_LEN];
    assign match_cnt  = cnt_q;
    assign err        = err_q;

endmodule

// File: doc/onehot_seq_detect.md
# onehot_seq_detect

Registered, parametrised one-hot sequence detector. It recognises an arbitrary serial bit pattern of length PAT_LEN, with overlapping or non-overlapping matching selectable at run time. It keeps a saturating match counter and detects and recovers from illegal (non-one-hot) state. It sits on a serial input stream and supplies a match strobe and count to downstream control logic. It generalises the fixed 4-state "101" one-hot next-state equations into a full FSM with state register, enable and error handling.

## Interface
- PAT_LEN, default 3: pattern length in bits, minimum 2, maximum 16. The FSM has PAT_LEN+1 one-hot states.
- PATTERN, default 3'b101: pattern to detect, PAT_LEN bits wide. The MSB is the first bit received.
- CNT_W, default 8: width of the match counter.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- resetn, input, 1: synchronous, active-low reset.
- en, input, 1: sample `in` this cycle. When low, state is held.
- in, input, 1: serial data bit.
- overlap, input, 1: 1 = overlapping matches, 0 = restart after a match.
- clr, input, 1: synchronous clear of match_cnt and err.
- state, output, PAT_LEN+1: registered one-hot state.
- next_state, output, PAT_LEN+1: combinational next state.
- out, output, 1: Moore match flag, equal to state[PAT_LEN].
- match_cnt, output, CNT_W: saturating count of matches.
- err, output, 1: sticky flag for an illegal-state event.

## Operation
- **States.** State Sk means the last k received bits equal the first k bits of PATTERN, for k = 0..PAT_LEN.
  - S0 is state[0].
  - S_PAT_LEN is the match state.
- **Transition from Sk, k < PAT_LEN, on bit b:**
  - If b == PATTERN[PAT_LEN-1-k], go to Sk+1.
  - Otherwise go to Sj, where j is the length of the longest proper suffix of (prefix_k, b) that is also a prefix of PATTERN. This is the KMP failure function. It is computed at elaboration, not at run time.
- **Transition from S_PAT_LEN on bit b:**
  - overlap=1: go to Sj, where j is the longest proper suffix of (PATTERN, b) that is a prefix of PATTERN.
  - overlap=0: take the same transition as S0 on b.
- **Reference case.** With PAT_LEN=3, PATTERN=101 and overlap=1, the next-state equations reduce to:
  - ns[0] = (s0|s2) & ~in
  - ns[1] = (s0|s1|s3) & in
  - ns[2] = (s1|s3) & ~in
  - ns[3] = s2 & in
- **Next-state logic.** next_state is the OR of all transitions of every set state bit. It is not a priority decode, so a legal one-hot state yields a one-hot next state.
- **Enable.** With en=0, next_state equals state, except when recovering from an illegal state (below).
- **Illegal state.** An illegal state is popcount(state) != 1.
  - The next register value is S0 (state = 1), regardless of en or in.
  - err is set and stays set until clr or reset.
  - No match is counted in that cycle.
- **Match counting.** match_cnt increments by 1 on each clock edge where en=1 and next_state[PAT_LEN]=1.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- **clr.** clr=1 zeroes match_cnt and err on that edge.
  - clr has priority over an increment or error set in the same cycle.
  - clr does not affect state.

## Timing
- Reset (resetn=0 at an edge) gives:
  - state = {PAT_LEN'b0, 1'b1}
  - out = 0
  - match_cnt = 0
  - err = 0
- resetn overrides en, clr and illegal-state recovery.
- Reset mid-pattern discards any partial match.
- Latency: out rises in the cycle after the edge that sampled the final pattern bit with en=1. out stays high until the next enabled sample moves the FSM out of S_PAT_LEN.
- match_cnt updates on the same edge that sets state[PAT_LEN].
- next_state is purely combinational from state, in, en and overlap.
- Changing overlap takes effect on the next enabled sample. It only alters transitions out of S_PAT_LEN.

## Structure
- Package onehot_seq_pkg holds:
  - the elaboration-time function kmp_next(pattern, len, k, b) returning the target index;
  - the constant S0_ONEHOT;
  - the helper function is_onehot.
- Sub-module onehot_seq_next: combinational next-state generator.
  - Inputs: state, in, overlap.
  - Output: raw next_state.
  - Parameters: PAT_LEN, PATTERN.
  - Built as a generate loop of per-bit OR terms, as in the reference equations.
- The top level adds: enable hold, illegal-state override, the state register, the counter and err.

## Test plan
- **Overlap, default parameters.** Reset, then en=1, overlap=1, in = 1,0,1,0,1 → out is high for one cycle after the 3rd bit and after the 5th bit; match_cnt = 2.
- **Non-overlap.** Same stimulus with overlap=0 → out high only after the 3rd bit; match_cnt = 1; the final state is S1 (state = 4'b0010).
- **Enable hold.** Input 1,0, then en=0 for 5 cycles with in toggling, then en=1 with in=1 → state is held at S2 (4'b0100) through the gap, then goes to S3 and out=1; match_cnt = 1.
- **Illegal state.** Force state = 4'b0110 for one cycle → next state = 4'b0001 and err=1. Then assert clr → err=0; match_cnt is unchanged by the recovery.
- **Saturation.** CNT_W=2, pattern 11, overlap=1, in held at 1 for 10 cycles → match_cnt rises to 3 and stays at 3. Reset mid-stream → all outputs return to their reset values on the next edge.
- **Exhaustive next state.** PAT_LEN=4, PATTERN=1101: drive every legal one-hot state with both values of in and both values of overlap → next_state matches the KMP-derived table in all 20 cases.
